mem_arbiter: RTL

- Single owner of the byte-wide synchronous RAM port. Shares it between two requesters: the instruction-fetch stage (word reads) and the MEM stage (byte/half/word loads and stores).
- Sequences multi-byte transfers one byte per cycle and returns a one-cycle done pulse to the winning requester.
- Aborts in-flight fetches on a taken jump, consistent with the pipeline flush of the ID/EX register.

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide synchronous RAM port between instruction fetch and MEM-stage loads/stores
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              jump_or_not,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr
);
    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    state_t            state_q;
    logic [2:0]        cnt_q, n_w;
    logic [1:0]        len_q, lane;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, buf_q, buf_d, if_inst_q, mem_rdata_q;
    logic              if_done_q, mem_done_q, rd;

    // Fetches are always words; length code 3 is treated as a word
    assign n_w  = (state_q == IF_RD || len_q[1]) ? 3'd4 : (len_q[0] ? 3'd2 : 3'd1);
    assign rd   = state_q == IF_RD || state_q == MEM_RD;
    assign lane = cnt_q[1:0] - 2'd1;

    assign ram_a    = (state_q != IDLE && cnt_q < n_w) ? addr_q + ADDR_W'(cnt_q) : '0;
    assign ram_dout = (state_q == MEM_WR) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
    assign ram_wr   = state_q == MEM_WR && rdy;

    assign if_done   = if_done_q;
    assign if_inst   = if_inst_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;

    // RAM data lags the address by one cycle, so byte cnt-1 arrives while cnt is presented
    always_comb begin
        buf_d = buf_q;
        if (rd && cnt_q != 3'd0) buf_d[{lane, 3'b000} +: 8] = ram_din;
    end

    // Arbitration and byte sequencing; everything freezes while rdy is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            len_q       <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else if (rdy) begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= 3'd0;
                    buf_q <= '0;
                    if (mem_req) begin
                        state_q <= mem_we ? MEM_WR : MEM_RD;
                        addr_q  <= mem_addr;
                        len_q   <= mem_len;
                        wdata_q <= mem_wdata;
                    end else if (if_req && !jump_or_not) begin
                        state_q <= IF_RD;
                        addr_q  <= if_addr;
                    end
                end
                IF_RD, MEM_RD: begin
                    buf_q <= buf_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (state_q == IF_RD && jump_or_not) begin
                        state_q <= IDLE;
                    end else if (cnt_q == n_w) begin
                        state_q <= IDLE;
                        if (state_q == IF_RD) begin
                            if_done_q <= 1'b1;
                            if_inst_q <= buf_d;
                        end else begin
                            mem_done_q  <= 1'b1;
                            mem_rdata_q <= buf_d;
                        end
                    end
                end
                default: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == n_w - 3'd1) begin
                        state_q    <= IDLE;
                        mem_done_q <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
